// File: rtl/uart_rx_engine.sv
// UART receive engine: 2-flop synchroniser, start/data/stop framing FSM, and sticky
// status flags (rxrdy/perr/ferr/ovf) where a frame completion takes priority over a CPU clear.
module uart_rx_engine #(
    parameter int unsigned BAUD_CNT = 10416,
    parameter int unsigned CNT_W    = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rxrdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int unsigned HALF = BAUD_CNT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [1:0]       sync_q, sync_d;
    logic             eight_q, eight_d;
    logic             pen_q, pen_d;
    logic             ohel_q, ohel_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rxrdy_q, rxrdy_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;

    logic             rx_s;
    logic             complete;
    logic [3:0]       n_last;
    logic [7:0]       frame_data;
    logic             frame_par;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            sync_q    <= 2'b11;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            rx_data_q <= 8'h00;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            sync_q    <= sync_d;
            eight_q   <= eight_d;
            pen_q     <= pen_d;
            ohel_q    <= ohel_d;
            rx_data_q <= rx_data_d;
            rxrdy_q   <= rxrdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        sync_d    = {sync_q[0], rx};
        eight_d   = eight_q;
        pen_d     = pen_q;
        ohel_d    = ohel_q;
        rx_data_d = rx_data_q;
        rxrdy_d   = rxrdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
        complete  = 1'b0;

        // Index of the final sample: data bits plus optional parity, minus one
        n_last     = (eight_q ? 4'd7 : 4'd6) + {3'b000, pen_q};
        frame_data = {eight_q & shreg_q[7], shreg_q[6:0]};
        frame_par  = eight_q ? shreg_q[8] : shreg_q[7];

        if (clr_rdy) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    bit_d   = '0;
                    shreg_d = '0;
                    eight_d = eight;
                    pen_d   = pen;
                    ohel_d  = ohel;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d          = '0;
                    shreg_d[bit_q] = rx_s;
                    if (bit_q == n_last) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion overrides a same-cycle clear; the old byte then counts as read
        if (complete) begin
            rx_data_d = frame_data;
            rxrdy_d   = 1'b1;
            ferr_d    = ~rx_s;
            perr_d    = pen_q & (^frame_data ^ frame_par ^ ohel_q);
            ovf_d     = rxrdy_q & ~clr_rdy;
        end
    end

    assign rx_data = rx_data_q;
    assign rxrdy   = rxrdy_q;
    assign perr    = perr_q;
    assign ferr    = ferr_q;
    assign ovf     = ovf_q;

endmodule
